// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies a synchronised lock,
// then releases downstream domain resets in index order; restarts on lock loss.
module pll_lock_sequencer #(
   parameter int NUM_DOMAINS         = 3,
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int STAGGER_CYCLES      = 64,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   pll_locked,
   input  logic                   retry_req,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   ready,
   output logic                   fault,
   output logic [7:0]             lock_lost_cnt
);

   localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
   localparam int MAX_CD  = (LOCK_TIMEOUT_CYCLES > STAGGER_CYCLES) ? LOCK_TIMEOUT_CYCLES : STAGGER_CYCLES;
   localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam int IDX_W   = $clog2(NUM_DOMAINS + 1);
   localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN,
      FAULT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic [RTY_W-1:0] retry_cnt;
   logic             sync1;
   logic             locked_s;

   always_ff @(posedge refclk) begin
      if (rst) begin
         state         <= RESET_PLL;
         cnt           <= '0;
         idx           <= '0;
         retry_cnt     <= '0;
         sync1         <= 1'b0;
         locked_s      <= 1'b0;
         pll_rst       <= 1'b1;
         domain_rst    <= '1;
         ready         <= 1'b0;
         fault         <= 1'b0;
         lock_lost_cnt <= '0;
      end else begin
         sync1    <= pll_locked;
         locked_s <= sync1;
         // Lock loss once releasing has begun takes priority over all staging.
         if ((state == RELEASE || state == RUN) && !locked_s) begin
            state      <= RESET_PLL;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            ready      <= 1'b0;
            if (lock_lost_cnt != 8'hFF)
               lock_lost_cnt <= lock_lost_cnt + 8'd1;
         end else begin
            case (state)
               RESET_PLL: begin
                  pll_rst    <= 1'b1;
                  domain_rst <= '1;
                  ready      <= 1'b0;
                  if (cnt == CNT_W'(RST_PULSE_CYCLES - 1)) begin
                     state   <= WAIT_LOCK;
                     cnt     <= '0;
                     pll_rst <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               WAIT_LOCK: begin
                  if (locked_s) begin
                     state <= STABLE;
                     cnt   <= '0;
                  end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                     cnt     <= '0;
                     pll_rst <= 1'b1;
                     if (retry_cnt == RTY_W'(MAX_RETRIES)) begin
                        state <= FAULT;
                        fault <= 1'b1;
                     end else begin
                        state     <= RESET_PLL;
                        retry_cnt <= retry_cnt + RTY_W'(1);
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               STABLE: begin
                  if (!locked_s) begin
                     state <= WAIT_LOCK;
                     cnt   <= '0;
                  end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                     state <= RELEASE;
                     cnt   <= '0;
                     idx   <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               RELEASE: begin
                  if (idx == IDX_W'(NUM_DOMAINS)) begin
                     state     <= RUN;
                     ready     <= 1'b1;
                     retry_cnt <= '0;
                  end else if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
                     cnt        <= '0;
                     domain_rst <= domain_rst & ~(NUM_DOMAINS'(1) << idx);
                     idx        <= idx + IDX_W'(1);
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               RUN: begin
                  ready <= 1'b1;
               end
               FAULT: begin
                  pll_rst    <= 1'b1;
                  domain_rst <= '1;
                  ready      <= 1'b0;
                  if (retry_req) begin
                     state     <= RESET_PLL;
                     fault     <= 1'b0;
                     retry_cnt <= '0;
                     cnt       <= '0;
                  end
               end
               default: begin
                  state <= RESET_PLL;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer using small cycle parameters.
module tb_pll_lock_sequencer;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       retry_req;
   logic       pll_rst;
   logic [2:0] domain_rst;
   logic       ready;
   logic       fault;
   logic [7:0] lock_lost_cnt;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   pll_lock_sequencer #(
      .NUM_DOMAINS        (3),
      .RST_PULSE_CYCLES   (4),
      .LOCK_STABLE_CYCLES (8),
      .LOCK_TIMEOUT_CYCLES(32),
      .STAGGER_CYCLES     (2),
      .MAX_RETRIES        (2)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .retry_req    (retry_req),
      .pll_rst      (pll_rst),
      .domain_rst   (domain_rst),
      .ready        (ready),
      .fault        (fault),
      .lock_lost_cnt(lock_lost_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   typedef struct {
      logic       rst;
      logic       lk;
      logic       pll;
      logic [2:0] dom;
      logic       rdy;
      int         reps;
   } vec_t;

   vec_t tbl[7];

   task automatic step();
      @(posedge refclk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Drop pll_locked for one edge, check the immediate teardown, time the rerun.
   task automatic lose_lock();
      int k;
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      step();
      step();
      chk("loss_ready", ready, 0);
      chk("loss_domain_rst", domain_rst, 7);
      chk("loss_pll_rst", pll_rst, 1);
      k = 0;
      while (ready !== 1'b1 && k < 40) begin
         step();
         k++;
      end
      chk("relock_cycles", k, 20);
   endtask

   initial begin
      int k;
      int rises;
      int fault_at;
      logic prev;

      rst = 1'b1;
      pll_locked = 1'b1;
      retry_req = 1'b0;

      tbl[0] = '{rst: 1'b1, lk: 1'b1, pll: 1'b1, dom: 3'b111, rdy: 1'b0, reps: 1};
      tbl[1] = '{rst: 1'b0, lk: 1'b1, pll: 1'b1, dom: 3'b111, rdy: 1'b0, reps: 3};
      tbl[2] = '{rst: 1'b0, lk: 1'b1, pll: 1'b0, dom: 3'b111, rdy: 1'b0, reps: 11};
      tbl[3] = '{rst: 1'b0, lk: 1'b1, pll: 1'b0, dom: 3'b110, rdy: 1'b0, reps: 2};
      tbl[4] = '{rst: 1'b0, lk: 1'b1, pll: 1'b0, dom: 3'b100, rdy: 1'b0, reps: 2};
      tbl[5] = '{rst: 1'b0, lk: 1'b1, pll: 1'b0, dom: 3'b000, rdy: 1'b0, reps: 1};
      tbl[6] = '{rst: 1'b0, lk: 1'b1, pll: 1'b0, dom: 3'b000, rdy: 1'b1, reps: 3};

      // Clean lock from power-up
      for (int i = 0; i < 7; i++) begin
         for (int r = 0; r < tbl[i].reps; r++) begin
            rst = tbl[i].rst;
            pll_locked = tbl[i].lk;
            step();
            chk($sformatf("vec%0d_pll_rst", i), pll_rst, tbl[i].pll);
            chk($sformatf("vec%0d_domain_rst", i), domain_rst, tbl[i].dom);
            chk($sformatf("vec%0d_ready", i), ready, tbl[i].rdy);
            chk($sformatf("vec%0d_fault", i), fault, 0);
            if (i == 0) chk("reset_lock_lost_cnt", lock_lost_cnt, 0);
         end
      end

      // One-cycle glitch seen by the FSM at STABLE count 5
      rst = 1'b1;
      pll_locked = 1'b1;
      step();
      rst = 1'b0;
      cyc = 0;
      for (int e = 1; e <= 27; e++) begin
         pll_locked = (e == 9) ? 1'b0 : 1'b1;
         step();
         if (e == 11) begin
            chk("glitch_wait_pll_rst", pll_rst, 0);
            chk("glitch_wait_dom", domain_rst, 7);
         end
         if (e == 21) chk("glitch_dom_e21", domain_rst, 7);
         if (e == 22) chk("glitch_dom_e22", domain_rst, 6);
         if (e == 26) chk("glitch_ready_e26", ready, 0);
         if (e == 27) chk("glitch_ready_e27", ready, 1);
      end

      // No lock: three timeouts then FAULT; retry_req ignored in WAIT_LOCK
      rst = 1'b1;
      pll_locked = 1'b0;
      step();
      rst = 1'b0;
      cyc = 0;
      prev = pll_rst;
      rises = 0;
      fault_at = -1;
      for (int e = 1; e <= 115; e++) begin
         retry_req = (e == 20) ? 1'b1 : 1'b0;
         step();
         retry_req = 1'b0;
         if (pll_rst === 1'b1 && prev === 1'b0) rises++;
         prev = pll_rst;
         if (fault === 1'b1 && fault_at < 0) fault_at = e;
         if (e == 35) chk("timeout1_pre_pll_rst", pll_rst, 0);
         if (e == 36) chk("timeout1_pll_rst", pll_rst, 1);
      end
      chk("pll_rst_rises", rises, 3);
      chk("fault_cycle", fault_at, 108);
      chk("fault_flag", fault, 1);
      chk("fault_pll_rst", pll_rst, 1);
      chk("fault_dom", domain_rst, 7);
      chk("fault_ready", ready, 0);

      pll_locked = 1'b1;
      retry_req = 1'b1;
      step();
      retry_req = 1'b0;
      chk("retry_fault_clear", fault, 0);
      chk("retry_pll_rst", pll_rst, 1);
      for (int e = 0; e < 3; e++) begin
         step();
         chk("retry_pulse_pll_rst", pll_rst, 1);
      end
      step();
      chk("retry_pulse_end", pll_rst, 0);
      k = 0;
      while (ready !== 1'b1 && k < 40) begin
         step();
         k++;
      end
      chk("retry_reaches_ready", ready, 1);
      chk("run_dom", domain_rst, 0);
      chk("run_lock_lost_cnt", lock_lost_cnt, 0);

      // Lock loss in RUN, then saturation of the loss counter
      lose_lock();
      chk("lock_lost_cnt_1", lock_lost_cnt, 1);
      for (int n = 2; n <= 260; n++) begin
         lose_lock();
         chk($sformatf("lock_lost_cnt_%0d", n), lock_lost_cnt, (n > 255) ? 255 : n);
      end

      // rst in mid-RELEASE
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      step();
      k = 0;
      while (domain_rst !== 3'b110 && k < 40) begin
         step();
         k++;
      end
      chk("reach_dom_110", domain_rst, 6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_pll_rst", pll_rst, 1);
      chk("midrst_dom", domain_rst, 7);
      chk("midrst_ready", ready, 0);
      chk("midrst_fault", fault, 0);
      chk("midrst_lock_lost_cnt", lock_lost_cnt, 0);
      for (int e = 0; e < 3; e++) begin
         step();
         chk("midrst_pulse_pll_rst", pll_rst, 1);
      end
      step();
      chk("midrst_pulse_end", pll_rst, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
